// File: rtl/sec_encoder_awe_24bits_clk_if.sv
// sec_encoder_awe_24bits_clk_if: start/busy/done handshake and data/code-word bus of the SEC encoder
interface sec_encoder_awe_24bits_clk_if #(
    parameter int D_BITS = 24,
    parameter int W_BITS = 32
);
    logic              start;
    logic [D_BITS-1:0] D;
    logic              busy;
    logic              done;
    logic [W_BITS-1:0] W;
    modport master (output start, D, input busy, done, W);
    modport slave (input start, D, output busy, done, W);
endinterface

// File: rtl/sec_encoder_awe_24bits_clk.sv
// sec_encoder_awe_24bits_clk: iterative Hamming SEC encoder, 24-bit data to 29-bit code zero-padded to 32 bits
module sec_encoder_awe_24bits_clk #(
    parameter int D_BITS = 24,
    parameter int W_BITS = 32,
    parameter int P_BITS = 5,
    parameter int BPC    = 4
) (
    input logic clk,
    input logic rst,
    sec_encoder_awe_24bits_clk_if.slave bus
);
    localparam int NCH    = D_BITS / BPC;
    localparam int CW     = NCH > 1 ? $clog2(NCH) : 1;
    localparam int C_BITS = D_BITS + P_BITS;
    typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
    state_t                   state, state_n;
    logic [D_BITS-1:0]        data_r, data_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [P_BITS-1:0]        acc, acc_n, acc_step;
    logic [W_BITS-1:0]        w_r, w_n, code;
    logic [D_BITS*P_BITS-1:0] pos_vec;
    logic [BPC-1:0]           chunk;
    logic [BPC*P_BITS-1:0]    pos_chunk;
    // Code position of data bit i: the i-th position that is not a power of two
    function automatic int data_pos(input int i);
        int n = 0;
        int r = 0;
        for (int q = 3; q < 64; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == i) r = q;
                n++;
            end
        end
        return r;
    endfunction
    genvar g;
    for (g = 0; g < D_BITS; g++) begin : g_data
        assign pos_vec[g*P_BITS +: P_BITS] = P_BITS'(data_pos(g));
        assign code[data_pos(g)-1]         = data_r[g];
    end
    for (g = 0; g < P_BITS; g++) begin : g_par
        assign code[(1 << g) - 1] = acc_step[g];
    end
    assign code[W_BITS-1:C_BITS] = '0;
    assign chunk     = BPC'(data_r >> (cnt * BPC));
    assign pos_chunk = (BPC*P_BITS)'(pos_vec >> (cnt * BPC * P_BITS));
    assign bus.busy  = state == ENCODE;
    assign bus.done  = state == DONE;
    assign bus.W     = w_r;
    // Fold the positions of the set bits of the current chunk into the parity accumulator
    always_comb begin
        acc_step = acc;
        for (int j = 0; j < BPC; j++)
            acc_step = chunk[j] ? acc_step ^ pos_chunk[j*P_BITS +: P_BITS] : acc_step;
    end
    // Handshake FSM: capture on start, accumulate one chunk per cycle, register the code word on the last chunk
    always_comb begin
        state_n = state;
        data_n  = data_r;
        cnt_n   = cnt;
        acc_n   = acc;
        w_n     = w_r;
        case (state)
            IDLE, DONE: if (bus.start) begin
                data_n  = bus.D;
                cnt_n   = '0;
                acc_n   = '0;
                state_n = ENCODE;
            end
            ENCODE: begin
                acc_n = acc_step;
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(NCH - 1)) begin
                    w_n     = code;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_r <= '0;
            cnt    <= '0;
            acc    <= '0;
            w_r    <= '0;
        end else begin
            state  <= state_n;
            data_r <= data_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            w_r    <= w_n;
        end
    end
endmodule

// File: tb/tb_sec_encoder_awe_24bits_clk.sv
// tb_sec_encoder_awe_24bits_clk: directed and random checks of the SEC encoder for BPC 4, 1 and 24
module tb_sec_encoder_awe_24bits_clk;
    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;
    sec_encoder_awe_24bits_clk_if b4 ();
    sec_encoder_awe_24bits_clk_if b1 ();
    sec_encoder_awe_24bits_clk_if b24 ();
    sec_encoder_awe_24bits_clk #(.BPC(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
    sec_encoder_awe_24bits_clk #(.BPC(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    sec_encoder_awe_24bits_clk #(.BPC(24)) u24 (.clk(clk), .rst(rst), .bus(b24));
    always #5 clk = ~clk;

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Classic Hamming construction: place data, then each parity bit covers positions with bit k set
    function automatic logic [31:0] ref_code(input logic [23:0] d);
        logic [31:0] w = '0;
        int n = 0;
        for (int p = 1; p <= 29; p++) if (!is_pow2(p)) begin w[p-1] = d[n]; n++; end
        for (int k = 0; k < 5; k++) begin
            logic par = 0;
            for (int p = 1; p <= 29; p++) if (((p >> k) & 1) == 1 && p != (1 << k)) par ^= w[p-1];
            w[(1 << k) - 1] = par;
        end
        return w;
    endfunction

    function automatic int syndrome(input logic [31:0] w);
        int s = 0;
        for (int p = 1; p <= 29; p++) if (w[p-1]) s ^= p;
        return s;
    endfunction

    function automatic logic [23:0] extract(input logic [31:0] w);
        logic [23:0] d = '0;
        int n = 0;
        for (int p = 1; p <= 29; p++) if (!is_pow2(p)) begin d[n] = w[p-1]; n++; end
        return d;
    endfunction

    // Decoder model: zero syndrome clean, every single flip located and corrected back to d
    function automatic bit decode_ok(input logic [31:0] w, input logic [23:0] d);
        bit ok = 1;
        logic [31:0] cw;
        int s;
        if (syndrome(w) != 0 || w[31:29] != 3'b000 || extract(w) != d) ok = 0;
        for (int p = 1; p <= 29; p++) begin
            cw = w;
            cw[p-1] = ~cw[p-1];
            s = syndrome(cw);
            if (s != p) ok = 0;
            else cw[s-1] = ~cw[s-1];
            if (extract(cw) != d) ok = 0;
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start all three encoders on the same word and check result and latency of each
    task automatic encode_all(input logic [23:0] d, input string tag, input bit chk_busy, input bit chk_dec);
        int l4 = 0, l1 = 0, l24 = 0, nb;
        logic [31:0] e = ref_code(d);
        b4.start = 1; b1.start = 1; b24.start = 1;
        b4.D = d; b1.D = d; b24.D = d;
        tick();
        b4.start = 0; b1.start = 0; b24.start = 0;
        b4.D = ~d; b1.D = ~d; b24.D = ~d;
        nb = int'(b4.busy);
        for (int c = 1; c <= 40 && (l4 == 0 || l1 == 0 || l24 == 0); c++) begin
            tick();
            if (b4.busy) nb++;
            if (l4 == 0 && b4.done) l4 = c;
            if (l1 == 0 && b1.done) l1 = c;
            if (l24 == 0 && b24.done) l24 = c;
        end
        chk({tag, " W bpc4"}, b4.W, e);
        chk({tag, " W bpc1"}, b1.W, e);
        chk({tag, " W bpc24"}, b24.W, e);
        chk({tag, " lat bpc4"}, l4, 6);
        chk({tag, " lat bpc1"}, l1, 24);
        chk({tag, " lat bpc24"}, l24, 1);
        if (chk_busy) chk({tag, " busy cycles"}, nb, 6);
        if (chk_dec) chk({tag, " decode"}, 32'(decode_ok(b4.W, d)), 1);
    endtask

    initial begin
        logic [23:0] d1, d2;
        logic [23:0] v [0:7];
        logic [31:0] prev_w;
        logic prev_done;
        bit stable;
        int k, last, lat;
        b4.start = 0; b1.start = 0; b24.start = 0;
        b4.D = '0; b1.D = '0; b24.D = '0;
        repeat (2) tick();
        rst = 0;
        chk("reset busy", 32'(b4.busy), 0);
        chk("reset done", 32'(b4.done), 0);
        chk("reset W", b4.W, 0);
        chk("reset done bpc1", 32'(b1.done), 0);

        encode_all(24'h000000, "zero", 1, 1);
        chk("zero const", b4.W, 32'h00000000);
        encode_all(24'hFFFFFF, "ones", 1, 1);
        chk("ones const", b4.W, 32'h1FFFFFFE);
        encode_all(24'h000001, "lsb", 0, 1);
        chk("lsb const", b4.W, 32'h00000007);
        encode_all(24'h800000, "msb", 0, 1);
        chk("msb const", b4.W, 32'h10008089);

        d1 = 24'($urandom); d2 = ~d1;
        b4.start = 1; b4.D = d1;
        tick();
        b4.start = 0; b4.D = d2;
        tick(); tick();
        b4.start = 1;
        tick();
        b4.start = 0;
        lat = 3;
        for (int c = 0; c < 20 && !b4.done; c++) begin tick(); lat++; end
        chk("ignore start W", b4.W, ref_code(d1));
        chk("ignore start lat", lat, 6);
        prev_w = b4.W;
        repeat (3) tick();
        chk("done level", 32'(b4.done), 1);
        chk("done hold W", b4.W, prev_w);

        for (int i = 0; i < 8; i++) v[i] = 24'($urandom);
        b4.start = 1; b4.D = v[0];
        k = 0; last = -1; stable = 1;
        prev_done = b4.done; prev_w = b4.W;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (b4.done && !prev_done) begin
                chk("b2b W", b4.W, ref_code(v[k]));
                if (last >= 0) chk("b2b period", c - last, 7);
                last = c;
                k++;
                b4.D = v[k];
            end else if (b4.W !== prev_w) stable = 0;
            prev_done = b4.done; prev_w = b4.W;
        end
        b4.start = 0;
        chk("b2b W stable", 32'(stable), 1);
        chk("b2b count", k, 5);
        for (int c = 0; c < 20 && !b4.done; c++) tick();

        b4.start = 1; b4.D = 24'($urandom);
        tick();
        b4.start = 0;
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid reset busy", 32'(b4.busy), 0);
        chk("mid reset done", 32'(b4.done), 0);
        chk("mid reset W", b4.W, 0);
        encode_all(24'($urandom), "after reset", 1, 1);

        for (int i = 0; i < 1000; i++) encode_all(24'($urandom), "random", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
